// File: rtl/muldiv_pkg.sv
// Shared constants, opcode encodings and FSM state type for the
// iterative multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;
  localparam int ITER  = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit, including the FSM state
// for observation.
// Handshake: start is taken only while busy=0 and flush=0; done pulses for one
// cycle when hi/lo have been loaded by a completed operation.
interface muldiv_if import muldiv_pkg::*; ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  state_e          state;

  modport master (
    output start, op, a, b, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo, state
  );

  modport slave (
    input  start, op, a, b, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo, state
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: right-shifting shift-add multiply, or
// left-shifting restoring divide with a 33-bit trial subtract.
module muldiv_step import muldiv_pkg::*; (
  input  logic [2*XLEN-1:0] work,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] work_nxt
);
  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  always_comb begin
    sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, operand} : '0);
    // Top 33 bits are the remainder already shifted left by one.
    trial = work[2*XLEN-1:XLEN-1] - {1'b0, operand};
    if (is_div) begin
      if (trial[XLEN])
        work_nxt = {work[2*XLEN-2:0], 1'b0};
      else
        work_nxt = {trial[XLEN-1:0], work[XLEN-2:0], 1'b1};
    end else begin
      work_nxt = {sum, work[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// MIPS EX-stage multiply/divide unit: FSM, iteration counter, sign/zero
// flags, result fix-up and the architectural HI/LO registers.
module muldiv_unit import muldiv_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] work, work_nxt;
  logic [XLEN-1:0]   opnd, a_raw;
  logic              is_div, neg_res, neg_rem, div0;
  logic              done_r;
  logic [XLEN-1:0]   hi_r, lo_r;

  logic              accept, last_iter, is_signed;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign last_iter = (cnt == CNT_W'(ITER - 1));
  assign is_signed = !bus.op[0];
  assign abs_a     = (is_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign abs_b     = (is_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

  muldiv_step u_step (
    .work     (work),
    .operand  (opnd),
    .is_div   (is_div),
    .work_nxt (work_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      work    <= {{XLEN{1'b0}}, abs_a};
      opnd    <= abs_b;
      a_raw   <= bus.a;
      is_div  <= bus.op[1];
      neg_res <= is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
      neg_rem <= is_signed && bus.a[XLEN-1];
      div0    <= (bus.b == '0);
    end else if (state == CALC) begin
      work <= work_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // Divide by zero keeps the raw dividend in HI regardless of signedness.
  always_comb begin
    prod_fix = neg_res ? -work : work;
    if (div0) begin
      quo_fix = '1;
      rem_fix = a_raw;
    end else begin
      quo_fix = neg_res ? -work[XLEN-1:0]      : work[XLEN-1:0];
      rem_fix = neg_rem ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == FIX && !bus.flush) begin
        done_r <= 1'b1;
        if (is_div) begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end else begin
          hi_r <= prod_fix[2*XLEN-1:XLEN];
          lo_r <= prod_fix[XLEN-1:0];
        end
      end else if (state == IDLE && !bus.start) begin
        if (bus.mthi) hi_r <= bus.wdata;
        if (bus.mtlo) lo_r <= bus.wdata;
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized
// operations against an arithmetic reference model, and control sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [63:0] exp_q[$];

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Launches at the current negedge; disturb_at >= 0 issues a stray start and
  // mtlo at that observation cycle, which must both be ignored.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int disturb_at);
    int busy_cnt;
    bit seen;
    logic [63:0] e;
    string tag;
    tag = $sformatf("op%0d %h/%h", op, a, b);
    exp_q.push_back(model(op, a, b));
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (i == disturb_at) begin
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
        bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
        $display("note: protocol error injected (start/mtlo while busy)");
      end else begin
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    e = exp_q.pop_front();
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, " hi"}, 64'(bus.hi), 64'(e[63:32]));
      check({tag, " lo"}, 64'(bus.lo), 64'(e[31:0]));
      check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    bit          done_seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed corner cases
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu max hi", 64'(bus.hi), 64'hFFFF_FFFE);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, -1);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, -1);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div ovf lo", 64'(bus.lo), 64'h8000_0000);
    run_op(OP_DIVU,  32'd100, 32'd0, -1);
    check("divu0 hi", 64'(bus.hi), 64'h64);
    run_op(OP_DIV,   32'hFFFF_FF00, 32'd0, -1);

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, -1);
    end

    // mthi / mtlo in IDLE
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h55AA;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthi+mtlo hi", 64'(bus.hi), 64'h55AA);
    check("mthi+mtlo lo", 64'(bus.lo), 64'h55AA);
    bus.mthi = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi lo kept", 64'(bus.lo), 64'h55AA);

    // stray start/mtlo while busy are ignored
    run_op(OP_MULTU, 32'd5, 32'd6, 3);
    check("5x6 lo", 64'(bus.lo), 64'd30);

    // flush mid-operation
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = $urandom; bus.b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush hi", 64'(bus.hi), 64'd0);
    check("flush lo", 64'(bus.lo), 64'd30);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("flush no done", 64'(done_seen), 64'd0);
    check("flush lo held", 64'(bus.lo), 64'd30);

    // flush together with start in IDLE drops the start
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start busy", 64'(bus.busy), 64'd0);

    // asynchronous reset mid-operation
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd7; bus.b = 32'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid hi", 64'(bus.hi), 64'd0);
    check("rst mid lo", 64'(bus.lo), 64'd0);
    check("rst mid busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst done", 64'(bus.done), 64'd0);
    run_op(OP_DIVU, 32'd1000, 32'd7, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
